// File: rtl/vga_timing_pkg.sv
// Shared raster constants and coordinate types for the VGA display path.
// Defaults describe 800x600@72Hz at a 50 MHz pixel rate.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 56;
  localparam int H_SYNC_DEF    = 120;
  localparam int H_BACK_DEF    = 64;
  localparam int H_TOTAL       = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 37;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BACK_DEF    = 23;
  localparam int V_TOTAL       = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [10:0] h_coord_t;
  typedef logic [9:0]  v_coord_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel clock-enable divider: o_tick is high one i_clk in every CLK_DIV,
// first on the CLK_DIV-th clock after reset release.
module pix_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  // A 1-bit counter is kept even for CLK_DIV==1; it simply stays at zero.
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] r_div;

  assign o_tick = (r_div == W'(CLK_DIV - 1));

  // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (o_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v scan counters advanced on each pixel tick, with
// coordinates, display-enable, syncs and start strobes registered together.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV    = 1,
  parameter int   H_VISIBLE  = H_VISIBLE_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_VISIBLE  = V_VISIBLE_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_pix_en,
  output logic [10:0] o_h_coord,
  output logic [9:0]  o_v_coord,
  output logic        o_disp_enbl,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (LINE_LEN > 2048 || FRAME_LINES > 1024 || CLK_DIV < 1 ||
      H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_params
    $fatal(1, "vga_timing_gen: illegal timing parameters");
  end

  localparam h_coord_t H_VIS_C  = h_coord_t'(H_VISIBLE);
  localparam h_coord_t HS_START = h_coord_t'(H_VISIBLE + H_FRONT);
  localparam h_coord_t HS_END   = h_coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam h_coord_t H_LAST   = h_coord_t'(LINE_LEN - 1);
  localparam v_coord_t V_VIS_C  = v_coord_t'(V_VISIBLE);
  localparam v_coord_t VS_START = v_coord_t'(V_VISIBLE + V_FRONT);
  localparam v_coord_t VS_END   = v_coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam v_coord_t V_LAST   = v_coord_t'(FRAME_LINES - 1);

  logic     w_tick;
  h_coord_t r_h;
  v_coord_t r_v;
  logic     w_h_last;
  logic     w_v_last;
  logic     w_de;
  logic     w_hs_act;
  logic     w_vs_act;

  pix_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(w_tick)
  );

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_de     = (r_h < H_VIS_C) && (r_v < V_VIS_C);
  assign w_hs_act = (r_h >= HS_START) && (r_h < HS_END);
  assign w_vs_act = (r_v >= VS_START) && (r_v < VS_END);

  // Scan position of the pixel to be presented on the next tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 11'd1;
      end
    end
  end

  // Strobes are cleared every non-tick cycle; the rest hold between ticks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_en      <= 1'b0;
      o_h_coord     <= '0;
      o_v_coord     <= '0;
      o_disp_enbl   <= 1'b0;
      o_hsync       <= ~H_SYNC_POL;
      o_vsync       <= ~V_SYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_pix_en      <= w_tick;
      o_line_start  <= w_tick && (r_h == '0);
      o_frame_start <= w_tick && (r_h == '0) && (r_v == '0);
      if (w_tick) begin
        o_h_coord   <= r_h;
        o_v_coord   <= r_v;
        o_disp_enbl <= w_de;
        o_hsync     <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
        o_vsync     <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance, a shrunken 15x8 raster with
// negative hsync, and the same shrunken raster at CLK_DIV=2.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Index 0: default timing; 1: small raster, hsync active-low; 2: small raster, CLK_DIV=2.
  logic        pe [3];
  logic [10:0] hc [3];
  logic [9:0]  vc [3];
  logic        de [3];
  logic        hs [3];
  logic        vs [3];
  logic        ls [3];
  logic        fs [3];

  logic hs_idle [3];
  logic vs_idle [3];

  vga_timing_gen u_dut_d (
    .i_clk(clk), .i_rst(rst), .o_pix_en(pe[0]), .o_h_coord(hc[0]), .o_v_coord(vc[0]),
    .o_disp_enbl(de[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_line_start(ls[0]),
    .o_frame_start(fs[0])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
  ) u_dut_s (
    .i_clk(clk), .i_rst(rst), .o_pix_en(pe[1]), .o_h_coord(hc[1]), .o_v_coord(vc[1]),
    .o_disp_enbl(de[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_line_start(ls[1]),
    .o_frame_start(fs[1])
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_dut_s2 (
    .i_clk(clk), .i_rst(rst), .o_pix_en(pe[2]), .o_h_coord(hc[2]), .o_v_coord(vc[2]),
    .o_disp_enbl(de[2]), .o_hsync(hs[2]), .o_vsync(vs[2]), .o_line_start(ls[2]),
    .o_frame_start(fs[2])
  );

  typedef struct {
    int       ph;
    int       dut;
    int       n;
    int       h;
    int       v;
    logic [5:0] fl;   // {pe, de, hs, vs, ls, fs}
    string    nm;
  } vec_t;

  vec_t vec[$];

  int total = 0;
  int bad   = 0;

  int d_hs, d_de, d_ls;
  int s_vs, s_de, s_hs, s_fs, s_ls, s2_pe;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int ph, input int dut, input int n, input int h, input int v,
                     input logic [5:0] fl, input string nm);
    vec_t r;
    r.ph = ph; r.dut = dut; r.n = n; r.h = h; r.v = v; r.fl = fl; r.nm = nm;
    vec.push_back(r);
  endtask

  task automatic check_vec(input int i);
    int d;
    d = vec[i].dut;
    check({vec[i].nm, ".h"},  32'(hc[d]), 32'(vec[i].h));
    check({vec[i].nm, ".v"},  32'(vc[d]), 32'(vec[i].v));
    check({vec[i].nm, ".pe"}, 32'(pe[d]), 32'(vec[i].fl[5]));
    check({vec[i].nm, ".de"}, 32'(de[d]), 32'(vec[i].fl[4]));
    check({vec[i].nm, ".hs"}, 32'(hs[d]), 32'(vec[i].fl[3]));
    check({vec[i].nm, ".vs"}, 32'(vs[d]), 32'(vec[i].fl[2]));
    check({vec[i].nm, ".ls"}, 32'(ls[d]), 32'(vec[i].fl[1]));
    check({vec[i].nm, ".fs"}, 32'(fs[d]), 32'(vec[i].fl[0]));
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      string p;
      p = $sformatf("%s[%0d]", tag, d);
      check({p, ".pe"}, 32'(pe[d]), 32'd0);
      check({p, ".h"},  32'(hc[d]), 32'd0);
      check({p, ".v"},  32'(vc[d]), 32'd0);
      check({p, ".de"}, 32'(de[d]), 32'd0);
      check({p, ".hs"}, 32'(hs[d]), 32'(hs_idle[d]));
      check({p, ".vs"}, 32'(vs[d]), 32'(vs_idle[d]));
      check({p, ".ls"}, 32'(ls[d]), 32'd0);
      check({p, ".fs"}, 32'(fs[d]), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for the given number of clocks, check, then release on a falling edge.
  task automatic do_reset(input int clocks, input string tag);
    rst = 1'b1;
    repeat (clocks) @(posedge clk);
    #1;
    check_reset(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // n counts rising edges since reset release; outputs sampled 1 time unit after each edge.
  task automatic run_phase(input int ph, input int last_n);
    for (int n = 1; n <= last_n; n++) begin
      step();
      for (int i = 0; i < vec.size(); i++) begin
        if (vec[i].ph == ph && vec[i].n == n) check_vec(i);
      end
      if (ph == 1 && n >= 2082 && n <= 3121) begin
        d_hs += int'(hs[0]);
        d_de += int'(de[0]);
        d_ls += int'(ls[0]);
      end
      if (ph == 2 && n <= 120) begin
        s_vs += int'(vs[1]);
        s_de += int'(de[1]);
        s_hs += int'(!hs[1]);
        s_fs += int'(fs[1]);
        s_ls += int'(ls[1]);
      end
      if (ph == 2 && n <= 40) s2_pe += int'(pe[2]);
    end
  endtask

  initial begin
    hs_idle = '{1'b0, 1'b1, 1'b0};
    vs_idle = '{1'b0, 1'b0, 1'b0};
    d_hs = 0; d_de = 0; d_ls = 0;
    s_vs = 0; s_de = 0; s_hs = 0; s_fs = 0; s_ls = 0; s2_pe = 0;

    //  ph dut n     h     v   {pe,de,hs,vs,ls,fs}
    add(1, 0, 1,    0,    0, 6'b110011, "d_first");
    add(1, 0, 2,    1,    0, 6'b110000, "d_second");
    add(1, 0, 800,  799,  0, 6'b110000, "d_last_vis");
    add(1, 0, 801,  800,  0, 6'b100000, "d_first_blank");
    add(1, 0, 856,  855,  0, 6'b100000, "d_pre_hs");
    add(1, 0, 857,  856,  0, 6'b101000, "d_hs_on");
    add(1, 0, 976,  975,  0, 6'b101000, "d_hs_last");
    add(1, 0, 977,  976,  0, 6'b100000, "d_hs_off");
    add(1, 0, 1040, 1039, 0, 6'b100000, "d_line_end");
    add(1, 0, 1041, 0,    1, 6'b110010, "d_line1");
    add(1, 0, 2081, 0,    2, 6'b110010, "d_line2");
    add(1, 1, 1,    0,    0, 6'b111011, "s_first");
    add(1, 2, 1,    0,    0, 6'b000000, "s2_n1");
    add(1, 2, 2,    0,    0, 6'b110011, "s2_n2");
    add(1, 2, 3,    0,    0, 6'b010000, "s2_n3");
    add(1, 2, 4,    1,    0, 6'b110000, "s2_n4");
    add(1, 2, 31,   14,   0, 6'b000000, "s2_n31");
    add(1, 2, 32,   0,    1, 6'b110010, "s2_line1");
    add(2, 1, 76,   0,    5, 6'b101110, "s_vs_on");
    add(2, 1, 77,   1,    5, 6'b101100, "s_vs_h1");
    add(2, 1, 86,   10,   5, 6'b100100, "s_vs_hs");
    add(2, 1, 105,  14,   6, 6'b101100, "s_vs_last");
    add(2, 1, 106,  0,    7, 6'b101010, "s_vs_off");
    add(2, 1, 120,  14,   7, 6'b101000, "s_wrap_pre");
    add(2, 1, 121,  0,    0, 6'b111011, "s_wrap");
    add(3, 1, 51,   5,    3, 6'b111000, "s_mid");
    add(3, 0, 51,   50,   0, 6'b110000, "d_mid");

    do_reset(5, "rst_init");
    run_phase(1, 3121);
    check("d_line_hs_count", 32'(d_hs), 32'd120);
    check("d_line_de_count", 32'(d_de), 32'd800);
    check("d_line_ls_count", 32'(d_ls), 32'd1);

    do_reset(2, "rst_again");
    run_phase(2, 121);
    check("s_frame_vs_count", 32'(s_vs), 32'd30);
    check("s_frame_de_count", 32'(s_de), 32'd32);
    check("s_frame_hs_count", 32'(s_hs), 32'd24);
    check("s_frame_fs_count", 32'(s_fs), 32'd1);
    check("s_frame_ls_count", 32'(s_ls), 32'd8);
    check("s2_pe_count",      32'(s2_pe), 32'd20);

    // Mid-frame reset: asserted between edges, outputs must clear without waiting for a clock.
    do_reset(1, "rst_pre_mid");
    run_phase(3, 51);
    rst = 1'b1;
    #1;
    check_reset("rst_mid_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    step();
    check("after_mid.d_fs", 32'(fs[0]), 32'd1);
    check("after_mid.d_h",  32'(hc[0]), 32'd0);
    check("after_mid.d_v",  32'(vc[0]), 32'd0);
    check("after_mid.s_fs", 32'(fs[1]), 32'd1);
    check("after_mid.s_h",  32'(hc[1]), 32'd0);
    check("after_mid.s_v",  32'(vc[1]), 32'd0);
    check("after_mid.s_de", 32'(de[1]), 32'd1);
    check("after_mid.s2_pe", 32'(pe[2]), 32'd0);
    step();
    check("after_mid.s2_fs", 32'(fs[2]), 32'd1);
    check("after_mid.s2_h",  32'(hc[2]), 32'd0);
    check("after_mid.s2_v",  32'(vc[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
